conv_read_ctrl: RTL and testbench

- Control FSM directly upstream of the read-address counters in the CNN single-layer datapath.
- Sequences a full layer pass in three steps:
  - loads an IMG_W x IMG_W pixel image into the 16-entry register file through a write pointer;
  - drives the shared ReadEn strobe that advances the three read-address counters window by window;
  - marks accumulator clear and valid points for the MAC stage.
- One instance per layer; it owns all timing between pixel ingest and convolution read-out.

---
 rtl/cnn_ctrl_pkg.sv | 32 +++
 rtl/valid_delay_line.sv | 38 +++
 rtl/conv_read_ctrl.sv | 179 +++++++++++++++++
 tb/tb_conv_read_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : cnn_ctrl_pkg                                              |
// | Purpose  : Shared types, constants and helpers for the CNN layer     |
// |            read controller.                                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package cnn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CONV  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int ADDR_W        = 4;
   localparam int REGFILE_DEPTH = 16;

   // Number of output windows of a valid (no padding, stride 1) convolution.
   function automatic int calc_nw(input int img_w, input int ker);
      return (img_w - ker + 1) * (img_w - ker + 1);
   endfunction

   // Counter width for a range of n values; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/valid_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : valid_delay_line                                          |
// | Purpose  : DEPTH-stage 1-bit shift register; o_q is i_d delayed by   |
// |            exactly DEPTH clock edges. Async active-low reset.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module valid_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [DEPTH-1:0] r_sr;

   generate
      if (DEPTH == 1) begin : g_single
         // Single stage: plain flop.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sr <= '0;
            else        r_sr <= i_d;
         end
      end else begin : g_multi
         // Shift towards the MSB; the MSB is the oldest sample.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sr <= '0;
            else        r_sr <= {r_sr[DEPTH-2:0], i_d};
         end
      end
   endgenerate

   assign o_q = r_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_read_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv_read_ctrl                                            |
// | Purpose  : Layer-pass sequencer: loads IMG_W*IMG_W pixels into the   |
// |            register file, then strobes ReadEn KER times per window,  |
// |            marks acc_clr / out_valid for the MAC and pulses done.    |
// | Options  : CONV_READ_CTRL_PERF_EN adds the cycle_cnt[15:0] output.   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module conv_read_ctrl
   import cnn_ctrl_pkg::*;
#(
   parameter int IMG_W    = 4,
   parameter int KER      = 3,
   parameter int PIPE_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              WriteEn,
   output logic [ADDR_W-1:0] WriteReg,
   output logic              ReadEn,
   output logic              acc_clr,
   output logic              out_valid,
   output logic              busy,
`ifdef CONV_READ_CTRL_PERF_EN
   output logic [15:0]       cycle_cnt,
`endif
   output logic              done
);

   localparam int c_NPIX  = IMG_W * IMG_W;
   localparam int c_NW    = calc_nw(IMG_W, KER);
   localparam int c_PTR_W = cnt_w(c_NPIX);
   localparam int c_WIN_W = cnt_w(c_NW);
   localparam int c_TAP_W = cnt_w(KER);
   localparam int c_DRN_W = cnt_w(PIPE_LAT);

   localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(c_NPIX - 1);
   localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(c_NW - 1);
   localparam logic [c_TAP_W-1:0] c_TAP_LAST = c_TAP_W'(KER - 1);
   localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'(PIPE_LAT - 1);

   state_t               r_state;
   state_t               w_next_state;
   logic [c_PTR_W-1:0]   r_wptr;
   logic [c_WIN_W-1:0]   r_win;
   logic [c_TAP_W-1:0]   r_tap;
   logic [c_DRN_W-1:0]   r_drain;

   logic w_last_tap;
   logic w_last_win;
   logic w_drain_end;
   logic w_window_end;

   assign w_last_tap   = (r_tap == c_TAP_LAST);
   assign w_last_win   = (r_win == c_WIN_LAST);
   assign w_drain_end  = (r_drain == c_DRN_LAST);
   assign w_window_end = ReadEn & w_last_tap;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Next-state and strobe decode; outputs default low outside their state.
   always_comb begin
      w_next_state = r_state;
      in_ready     = 1'b0;
      WriteEn      = 1'b0;
      ReadEn       = 1'b0;
      acc_clr      = 1'b0;
      done         = 1'b0;
      busy         = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (start) w_next_state = LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            WriteEn  = in_valid;
            if (in_valid && (r_wptr == c_PTR_LAST)) w_next_state = CONV;
         end
         CONV: begin
            ReadEn  = 1'b1;
            acc_clr = (r_tap == '0);
            if (w_last_tap && w_last_win) w_next_state = DRAIN;
         end
         DRAIN: begin
            if (w_drain_end) w_next_state = DONE;
         end
         DONE: begin
            done         = 1'b1;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Register-file address is the write pointer, zero-extended.
   always_comb begin
      WriteReg              = '0;
      WriteReg[c_PTR_W-1:0] = r_wptr;
   end

   // Write pointer: advance per handshake, back to 0 after the last pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
      end else if (WriteEn) begin
         if (r_wptr == c_PTR_LAST) r_wptr <= '0;
         else                      r_wptr <= r_wptr + c_PTR_W'(1);
      end
   end

   // Tap counter: cycles 0..KER-1 for every window while convolving.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tap <= '0;
      end else if (r_state == CONV) begin
         if (w_last_tap) r_tap <= '0;
         else            r_tap <= r_tap + c_TAP_W'(1);
      end
   end

   // Window counter: cleared while idle, advances at each window end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win <= '0;
      end else if (r_state == IDLE) begin
         r_win <= '0;
      end else if (w_window_end && !w_last_win) begin
         r_win <= r_win + c_WIN_W'(1);
      end
   end

   // Drain counter: times PIPE_LAT cycles, cleared on leaving DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drain <= '0;
      end else if (r_state == DRAIN) begin
         if (w_drain_end) r_drain <= '0;
         else             r_drain <= r_drain + c_DRN_W'(1);
      end
   end

   valid_delay_line #(
      .DEPTH (PIPE_LAT)
   ) u_valid_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (w_window_end),
      .o_q   (out_valid)
   );

`ifdef CONV_READ_CTRL_PERF_EN
   logic [15:0] r_cycle_cnt;

   // Restart at the IDLE->LOAD edge (that edge counts), then count busy edges, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt <= '0;
      end else if ((r_state == IDLE) && start) begin
         r_cycle_cnt <= 16'd1;
      end else if (busy && (r_cycle_cnt != 16'hFFFF)) begin
         r_cycle_cnt <= r_cycle_cnt + 16'd1;
      end
   end

   assign cycle_cnt = r_cycle_cnt;
`else
   // Performance counter not built: no extra port or state.
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_read_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_conv_read_ctrl                                         |
// | Purpose  : Self-checking bench for conv_read_ctrl: cycle tables for  |
// |            default passes, write-address scoreboard, reset and       |
// |            IMG_W=3/KER=3/PIPE_LAT=3 sequences.                       |
// | Options  : CONV_READ_CTRL_PERF_EN also checks cycle_cnt.             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_conv_read_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   // default instance
   logic       start, in_valid;
   logic       in_ready, WriteEn, ReadEn, acc_clr, out_valid, busy, done;
   logic [3:0] WriteReg;
   // sweep instance
   logic       start_b, in_valid_b;
   logic       in_ready_b, WriteEn_b, ReadEn_b, acc_clr_b, out_valid_b, busy_b, done_b;
   logic [3:0] WriteReg_b;
`ifdef CONV_READ_CTRL_PERF_EN
   logic [15:0] cycle_cnt, cycle_cnt_b;
`endif

   conv_read_ctrl #(.IMG_W(4), .KER(3), .PIPE_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .WriteEn(WriteEn), .WriteReg(WriteReg),
      .ReadEn(ReadEn), .acc_clr(acc_clr), .out_valid(out_valid), .busy(busy),
`ifdef CONV_READ_CTRL_PERF_EN
      .cycle_cnt(cycle_cnt),
`endif
      .done(done)
   );

   conv_read_ctrl #(.IMG_W(3), .KER(3), .PIPE_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b),
      .in_ready(in_ready_b), .WriteEn(WriteEn_b), .WriteReg(WriteReg_b),
      .ReadEn(ReadEn_b), .acc_clr(acc_clr_b), .out_valid(out_valid_b), .busy(busy_b),
`ifdef CONV_READ_CTRL_PERF_EN
      .cycle_cnt(cycle_cnt_b),
`endif
      .done(done_b)
   );

   // {in_ready, WriteEn, WriteReg[3:0], ReadEn, acc_clr, out_valid, busy, done}
   typedef struct {
      string       tag;
      logic        start;
      logic        in_valid;
      logic [10:0] exp;
   } vec_t;

   vec_t       tbl[$];
   logic [3:0] addr_q[$];
   int         n_cmp = 0;
   int         n_fail = 0;

   function automatic logic [10:0] pk(input logic rdy, input logic we, input logic [3:0] wr,
                                      input logic re, input logic clr, input logic ov,
                                      input logic bsy, input logic dn);
      return {rdy, we, wr, re, clr, ov, bsy, dn};
   endfunction

   function automatic logic [10:0] act_a();
      return {in_ready, WriteEn, WriteReg, ReadEn, acc_clr, out_valid, busy, done};
   endfunction

   function void add(input string tag, input logic st, input logic iv, input logic [10:0] e);
      vec_t v;
      v.tag = tag; v.start = st; v.in_valid = iv; v.exp = e;
      tbl.push_back(v);
   endfunction

   // One complete default pass; 'stall' inserts an idle cycle before each
   // pixel, drives in_valid during CONV and pulses start while busy.
   function void build_pass(input bit stall);
      add("idle_start", 1'b1, 1'b0, pk(0, 0, 4'd0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 16; k++) begin
         if (stall) add("load_stall", (k == 5), 1'b0, pk(1, 0, 4'(k), 0, 0, 0, 1, 0));
         add("load_px", 1'b0, 1'b1, pk(1, 1, 4'(k), 0, 0, 0, 1, 0));
      end
      for (int c = 0; c < 12; c++)
         add("conv", stall && (c == 4), stall,
             pk(0, 0, 4'd0, 1, (c % 3 == 0), (c == 3 || c == 6 || c == 9), 1, 0));
      add("drain",      1'b0,  1'b0, pk(0, 0, 4'd0, 0, 0, 1, 1, 0));
      add("done",       stall, 1'b0, pk(0, 0, 4'd0, 0, 0, 0, 1, 1));
      add("idle_after", 1'b0,  1'b0, pk(0, 0, 4'd0, 0, 0, 0, 0, 0));
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [10:0] exp);
      logic [10:0] a;
      a = act_a();
      n_cmp++;
      if (a !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %b, want %b", name, $time, a, exp);
      end
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(negedge clk);
         start    = tbl[i].start;
         in_valid = tbl[i].in_valid;
         if (tbl[i].exp[9]) addr_q.push_back(tbl[i].exp[8:5]);
         #1;
         chk_vec($sformatf("%s[%0d]", tbl[i].tag, i - lo), tbl[i].exp);
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   // Write scoreboard: every observed WriteEn must match the next expected address.
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (WriteEn === 1'b1) begin
            n_cmp++;
            if (addr_q.size() == 0) begin
               n_fail++;
               $display("FAIL wr_unexpected: got addr %0d, want no write", WriteReg);
            end else begin
               e = addr_q.pop_front();
               if (WriteReg !== e) begin
                  n_fail++;
                  $display("FAIL wr_addr: got %0d, want %0d", WriteReg, e);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int plain_lo, plain_hi, stall_lo, stall_hi;
      int nwr, re_cnt, first_re, last_re, ov_cnt, ov_cyc, done_cnt, done_cyc, sent;
      bit clr_first;

      plain_lo = tbl.size(); build_pass(1'b0); plain_hi = tbl.size();
      stall_lo = tbl.size(); build_pass(1'b1); stall_hi = tbl.size();

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; start_b = 1'b0; in_valid_b = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk_vec("reset_state", 11'd0);
`ifdef CONV_READ_CTRL_PERF_EN
      chk("reset_cycle_cnt", int'(cycle_cnt), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-LOAD after 7 pixels.
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         start    = 1'b0;
         in_valid = 1'b1;
         addr_q.push_back(4'(k));
      end
      @(negedge clk);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1 chk_vec("midload_reset_async", 11'd0);
      @(negedge clk);
      in_valid = 1'b1;
      #1 chk_vec("in_reset_in_valid", 11'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk_vec("after_reset_idle", 11'd0);
      end
      chk("addr_q_after_reset", addr_q.size(), 0);

      // Full default pass, no stalls.
      run_rows(plain_lo, plain_hi);
`ifdef CONV_READ_CTRL_PERF_EN
      #1 chk("cycle_cnt_at_done", int'(cycle_cnt), 31);
      repeat (2) @(negedge clk);
      #1 chk("cycle_cnt_hold", int'(cycle_cnt), 31);
`endif

      // Stalled load plus start pulses while busy.
      run_rows(stall_lo, stall_hi);
      repeat (2) @(negedge clk);
      #1 chk_vec("no_restart_idle", 11'd0);
      chk("addr_q_drained", addr_q.size(), 0);

      // Parameter sweep: IMG_W=3, KER=3, PIPE_LAT=3.
      nwr = 0; re_cnt = 0; first_re = -1; last_re = -1; ov_cnt = 0; ov_cyc = -1;
      done_cnt = 0; done_cyc = -1; sent = 0; clr_first = 1'b0;
      @(negedge clk);
      start_b = 1'b1;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         start_b    = 1'b0;
         in_valid_b = (sent < 9);
         #1;
         if (WriteEn_b) begin
            chk("sweep_wr_addr", int'(WriteReg_b), nwr);
            nwr++;
         end
         if (in_valid_b && in_ready_b) sent++;
         if (ReadEn_b) begin
            if (first_re < 0) begin
               first_re  = cyc;
               clr_first = acc_clr_b;
            end
            re_cnt++;
            last_re = cyc;
         end
         if (out_valid_b) begin
            ov_cnt++;
            ov_cyc = cyc;
         end
         if (done_b) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (done_cyc > 0 && cyc >= done_cyc + 2) break;
      end
      in_valid_b = 1'b0;
      chk("sweep_done_count", done_cnt, 1);
      chk("sweep_writes", nwr, 9);
      chk("sweep_readen_cycles", re_cnt, 3);
      chk("sweep_readen_span", last_re - first_re, 2);
      chk("sweep_acc_clr_first", int'(clr_first), 1);
      chk("sweep_out_valid_count", ov_cnt, 1);
      chk("sweep_out_valid_delay", ov_cyc - last_re, 3);
      chk("sweep_done_after_ov", done_cyc - ov_cyc, 1);
      chk("sweep_idle_busy", int'(busy_b), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
